// File: rtl/ppm_pkg.sv
// ppm_pkg: shared types and helpers for the PPM demodulator and its frame sequencer.
//   state_t       - frame sequencer states
//   clog2()       - bit width needed to hold values 0..value-1
//   to_offset_bin - two's complement symbol to offset binary (MSB inversion)
package ppm_pkg;

    localparam int unsigned MAX_N = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ARM,
        ST_RUN,
        ST_CAPTURE,
        ST_GUARD,
        ST_DONE
    } state_t;

    // Smallest width w such that 2^w >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    // Flip bit (width-1): -2^(width-1) maps to 0, 2^(width-1)-1 maps to all ones.
    function automatic logic [MAX_N-1:0] to_offset_bin(input logic [MAX_N-1:0] data,
                                                       input int unsigned      width);
        return data ^ (MAX_N'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/ppm_frame_ctrl_if.sv
// ppm_frame_ctrl_if: request, demodulator and downstream frame signals of ppm_frame_ctrl.
//   slave  - sequencer view: i_frame_start, i_demod_ready, i_demod_data, i_out_ready in;
//            o_demod_start, o_frame, o_frame_valid, o_busy, o_error out
//   master - the opposite view, for the surrounding logic
interface ppm_frame_ctrl_if #(
    parameter int unsigned N       = 4,
    parameter int unsigned SYMBOLS = 4
);

    logic                   i_frame_start;
    logic                   i_demod_ready;
    logic [N-1:0]           i_demod_data;
    logic                   o_demod_start;
    logic                   i_out_ready;
    logic [N*SYMBOLS-1:0]   o_frame;
    logic                   o_frame_valid;
    logic                   o_busy;
    logic                   o_error;

    modport slave (
        input  i_frame_start,
        input  i_demod_ready,
        input  i_demod_data,
        input  i_out_ready,
        output o_demod_start,
        output o_frame,
        output o_frame_valid,
        output o_busy,
        output o_error
    );

    modport master (
        output i_frame_start,
        output i_demod_ready,
        output i_demod_data,
        output i_out_ready,
        input  o_demod_start,
        input  o_frame,
        input  o_frame_valid,
        input  o_busy,
        input  o_error
    );

endinterface

// File: rtl/ppm_cycle_timer.sv
// ppm_cycle_timer: loadable down-counter shared by the ARM timeout and the GUARD gap.
//   i_clk, i_rst      - clock, synchronous active-high reset
//   i_load, i_load_val - load the counter (load wins over decrement)
//   i_dec             - decrement, saturating at zero
//   o_zero_nxt_c      - count is 0 or 1: a decrement this cycle leaves it at zero
module ppm_cycle_timer #(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero_nxt_c
);

    logic [W-1:0] r_count;

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero_nxt_c = (r_count <= W'(1));

endmodule

// File: rtl/ppm_frame_ctrl.sv
// ppm_frame_ctrl: sequences one PPM demodulator through SYMBOLS slots and packs the
// offset-binary symbols into one frame word, first symbol in the MSBs.
//   i_clk, i_rst - clock, synchronous active-high reset
//   bus (slave)  - i_frame_start request; o_demod_start / i_demod_ready / i_demod_data
//                  to the demodulator; o_frame / o_frame_valid / i_out_ready downstream;
//                  o_busy (not IDLE); o_error (one-cycle demodulator timeout pulse)
module ppm_frame_ctrl
    import ppm_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned SYMBOLS = 4,
    parameter int unsigned GUARD   = 2,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    ppm_frame_ctrl_if.slave  bus
);

    localparam int unsigned FW    = N * SYMBOLS;
    localparam int unsigned CW    = clog2(SYMBOLS + 1);
    localparam int unsigned T_MAX = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
    localparam int unsigned TW    = clog2(T_MAX + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_sym_cnt;
    logic [FW-1:0]   r_frame;
    logic            r_demod_start;
    logic            r_frame_valid;
    logic            r_busy;
    logic            r_error;

    logic            w_tmr_load;
    logic [TW-1:0]   w_tmr_val;
    logic            w_tmr_dec;
    logic            w_tmr_zero_nxt;
    logic            w_clear;
    logic            w_capture;
    logic            w_error_nxt;
    logic            w_last_sym;
    logic [N-1:0]    w_symbol;

    assign w_symbol   = N'(to_offset_bin(MAX_N'(bus.i_demod_data), N));
    assign w_last_sym = (r_sym_cnt == CW'(SYMBOLS - 1));

    ppm_cycle_timer #(
        .W (TW)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (w_tmr_load),
        .i_load_val   (w_tmr_val),
        .i_dec        (w_tmr_dec),
        .o_zero_nxt_c (w_tmr_zero_nxt)
    );

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_dec   = 1'b0;
        w_clear     = 1'b0;
        w_capture   = 1'b0;
        w_error_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.i_frame_start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_tmr_load  = 1'b1;
                w_tmr_val   = TW'(TIMEOUT);
                w_state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (!bus.i_demod_ready) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_tmr_dec = 1'b1;
                    // Demodulator never acknowledged the start: drop the frame.
                    if (w_tmr_zero_nxt) begin
                        w_error_nxt = 1'b1;
                        w_clear     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (bus.i_demod_ready) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_capture = 1'b1;
                if (w_last_sym) begin
                    w_state_nxt = ST_DONE;
                end else if (GUARD == 0) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(GUARD);
                    w_state_nxt = ST_GUARD;
                end
            end
            ST_GUARD: begin
                w_tmr_dec = 1'b1;
                if (w_tmr_zero_nxt) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DONE: begin
                if (bus.i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, frame data and outputs; outputs are pre-decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_sym_cnt     <= '0;
            r_frame       <= '0;
            r_demod_start <= 1'b0;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_sym_cnt <= '0;
                r_frame   <= '0;
            end else if (w_capture) begin
                r_sym_cnt <= r_sym_cnt + CW'(1);
                r_frame   <= (r_frame << N) | FW'(w_symbol);
            end
            r_demod_start <= (w_state_nxt == ST_START);
            r_frame_valid <= (w_state_nxt == ST_DONE);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_error       <= w_error_nxt;
        end
    end

    assign bus.o_demod_start = r_demod_start;
    assign bus.o_frame       = r_frame;
    assign bus.o_frame_valid = r_frame_valid;
    assign bus.o_busy        = r_busy;
    assign bus.o_error       = r_error;

endmodule

// File: doc/ppm_frame_ctrl.md
# ppm_frame_ctrl

Frame-level sequencer for the N-bit PPM demodulator. On a frame request it issues one demodulator start per symbol slot, tracks the demodulator's ready/busy line, and captures each decoded symbol as offset-binary. It packs SYMBOLS symbols into one frame word and presents it downstream on a valid/ready handshake. It sits between the link-layer receiver logic and one demodulator instance, and owns that demodulator exclusively.

## Interface
- N, 4: demodulator symbol width in bits; one slot spans 2^N cycles.
- SYMBOLS, 4: symbols per frame, at least 1.
- GUARD, 2: idle cycles inserted between consecutive symbol slots, at least 0.
- TIMEOUT, 8: cycles allowed for the demodulator's ready line to drop after a start, at least 1.

- i_clk  in  1  single clock; all logic is on the rising edge.
- i_rst  in  1  reset, synchronous and active-high.
- i_frame_start  in  1  request to receive one frame; sampled only in IDLE.
- i_demod_ready  in  1  demodulator ready (1 = idle, 0 = slot in progress).
- i_demod_data  in  N  demodulator symbol, two's complement; valid when i_demod_ready is high.
- o_demod_start  out  1  one-cycle start pulse to the demodulator.
- i_out_ready  in  1  downstream accepts the frame.
- o_frame  out  N*SYMBOLS  packed frame; the first symbol received occupies the MSBs.
- o_frame_valid  out  1  o_frame is valid; held until accepted.
- o_busy  out  1  high in every state except IDLE.
- o_error  out  1  one-cycle pulse on a demodulator timeout.

## Operation
- The state machine is IDLE → START → ARM → RUN → CAPTURE → GUARD, then back to START, or on to DONE.
- IDLE: when i_frame_start is high, clear the symbol counter and frame shift register, then go to START. i_frame_start is ignored in every other state.
- START: drive o_demod_start = 1 for exactly this cycle, load the timer with TIMEOUT, go to ARM.
- ARM: if i_demod_ready = 0, go to RUN. Otherwise decrement the timer; if the timer reaches 0 with ready still high, pulse o_error and go to IDLE with the frame discarded.
- RUN: wait for i_demod_ready = 1, with no timeout (the slot length is fixed by the demodulator), then go to CAPTURE.
- CAPTURE: convert the symbol to offset binary, symbol = {~i_demod_data[N-1], i_demod_data[N-2:0]}, so -2^(N-1) maps to 0 and 2^(N-1)-1 maps to 2^N-1. Shift it into o_frame from the LSB end (frame = {frame[N*SYMBOLS-N-1:0], symbol}) and increment the symbol count.
  - If the count is now SYMBOLS, go to DONE.
  - Else if GUARD = 0, go to START.
  - Else load the timer with GUARD and go to GUARD.
- GUARD: decrement the timer; at 0, go to START.
- DONE: o_frame_valid = 1 and o_frame is stable. When i_out_ready = 1, the transfer completes and the next state is IDLE.
- Width rules:
  - The symbol counter is clog2(SYMBOLS+1) bits.
  - The timer is clog2(max(TIMEOUT, GUARD)+1) bits.
  - No arithmetic is performed on the symbol data beyond the MSB inversion.

## Timing
- Reset values: state IDLE, o_demod_start 0, o_frame_valid 0, o_busy 0, o_error 0, o_frame all zeros, counters 0.
- Reset asserted mid-frame returns the block to IDLE on the next edge, drops o_frame_valid, and issues no further start pulses.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- IDLE with i_frame_start high at edge k puts o_demod_start high during cycle k+1.
- With a demodulator that drops ready one cycle after start and stays busy for 2^N cycles, each slot takes 1 (START) + 1 (ARM) + 2^N (RUN) + 1 (CAPTURE) + GUARD cycles.
- o_frame_valid rises on the cycle after the last CAPTURE.
- DONE with i_out_ready already high holds valid for exactly one cycle. Back-to-back frames need i_frame_start in IDLE, so there is at least one idle cycle between a frame's acceptance and the next start pulse.
- If i_demod_ready is already low on entry to ARM, the transition to RUN is immediate and no timeout is counted.
- o_error and o_frame_valid are never high in the same cycle.

## Structure
- Shared package ppm_pkg holds:
  - the state enum (IDLE, START, ARM, RUN, CAPTURE, GUARD, DONE);
  - the to-offset-binary conversion function;
  - a clog2 helper.
  The demodulator testbench also uses this package.
- One sub-module, ppm_cycle_timer: a loadable down-counter with a zero flag. A single instance serves both the ARM timeout and the GUARD count.

## Test plan
Directed scenarios, all with N=4, SYMBOLS=2, GUARD=2, TIMEOUT=4, driven by a behavioural demodulator model:
- Nominal frame: demodulator returns -8 then 7 → o_frame = 8'h0F, valid held until i_out_ready, one start pulse per slot, GUARD = 2 idle cycles between slots.
- Timeout: ready never drops after start → o_error pulses exactly 4 cycles after START, state returns to IDLE, o_frame_valid never rises.
- Backpressure: i_out_ready low for 10 cycles in DONE → o_frame stays 8'h0F and valid stays high, no new start pulse, i_frame_start is ignored.
- Mid-frame reset: i_rst pulsed during the second RUN → all outputs at reset values next cycle, a subsequent frame of symbols 0 and -1 yields o_frame = 8'h87.
- Edge configuration: GUARD=0 and SYMBOLS=1, symbol 3 → o_frame = 4'hB, valid one cycle after CAPTURE.
- Busy-ignore: i_frame_start held high throughout a frame → exactly one frame is produced, and a new frame starts only after DONE completes and the block returns to IDLE.
